// File: rtl/siso_pkg.sv
// Shared types and default sizing for the SISO shift-register sequencer.
// The state encoding is fixed so it matches what the surrounding SISO code already uses.
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } siso_state_e;

    localparam int SISO_DEPTH = 4;
    localparam int SISO_WORD  = 8;

endpackage : siso_pkg

// File: rtl/siso_shift_ctrl.sv
// Loopback sequencer for a DEPTH-stage SISO shift register: serializes a word MSB-first
// onto sdi, re-captures it from the last stage and reports the word plus a match flag.
module siso_shift_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH = SISO_WORD,
    parameter int DEPTH = SISO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             sdi,
    input  logic             sdo,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             match
);

    localparam int CNT_W = $clog2(WIDTH + DEPTH);

    // Count values where the outgoing bits end, the capture window opens, and the last sample lands
    localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_CAP     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH + DEPTH - 1);

    siso_state_e      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] tx_hold_r, tx_hold_s;
    logic [WIDTH-1:0] tx_shift_r, tx_shift_s;
    logic [WIDTH-1:0] rx_shift_r, rx_shift_s;
    logic [WIDTH-1:0] rx_cap_s;
    logic             sdi_r, sdi_s;
    logic             done_valid_r, done_valid_s;
    logic [WIDTH-1:0] rx_data_r, rx_data_s;
    logic             match_r, match_s;
    logic             busy_r, busy_s;
    logic             start_ready_r, start_ready_s;

    // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        tx_hold_s    = tx_hold_r;
        tx_shift_s   = tx_shift_r;
        rx_shift_s   = rx_shift_r;
        sdi_s        = 1'b0;
        done_valid_s = done_valid_r;
        rx_data_s    = rx_data_r;
        match_s      = match_r;
        rx_cap_s     = rx_shift_r << 1;
        rx_cap_s[0]  = sdo;

        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    tx_hold_s  = tx_data;
                    sdi_s      = tx_data[WIDTH-1];
                    tx_shift_s = tx_data << 1;
                    rx_shift_s = '0;
                    cnt_s      = '0;
                    state_s    = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                cnt_s      = cnt_r + CNT_W'(1);
                tx_shift_s = tx_shift_r << 1;
                if (cnt_r < CNT_TX_LAST) begin
                    sdi_s = tx_shift_r[WIDTH-1];
                end else begin
                    sdi_s = 1'b0;
                end
                if (cnt_r >= CNT_CAP) begin
                    rx_shift_s = rx_cap_s;
                end else begin
                    rx_shift_s = rx_shift_r;
                end
                // Leaving SHIFT clears cnt so it cannot wrap when WIDTH+DEPTH is a power of two
                if (cnt_r == CNT_LAST) begin
                    state_s      = DONE;
                    cnt_s        = '0;
                    done_valid_s = 1'b1;
                    rx_data_s    = rx_cap_s;
                    match_s      = (rx_cap_s == tx_hold_r);
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_valid_s = 1'b0;
                    state_s      = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s      = IDLE;
                cnt_s        = '0;
                done_valid_s = 1'b0;
            end
        endcase

        busy_s        = (state_s != IDLE);
        start_ready_s = (state_s == IDLE);
    end

    // State and output registers; rst aborts any transfer and discards partial results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            tx_hold_r     <= '0;
            tx_shift_r    <= '0;
            rx_shift_r    <= '0;
            sdi_r         <= 1'b0;
            done_valid_r  <= 1'b0;
            rx_data_r     <= '0;
            match_r       <= 1'b0;
            busy_r        <= 1'b0;
            start_ready_r <= 1'b1;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            tx_hold_r     <= tx_hold_s;
            tx_shift_r    <= tx_shift_s;
            rx_shift_r    <= rx_shift_s;
            sdi_r         <= sdi_s;
            done_valid_r  <= done_valid_s;
            rx_data_r     <= rx_data_s;
            match_r       <= match_s;
            busy_r        <= busy_s;
            start_ready_r <= start_ready_s;
        end
    end

    assign start_ready = start_ready_r;
    assign sdi         = sdi_r;
    assign busy        = busy_r;
    assign done_valid  = done_valid_r;
    assign rx_data     = rx_data_r;
    assign match       = match_r;

endmodule : siso_shift_ctrl
